// File: rtl/vga_timing_gen_if.sv
// Video timing bundle produced by vga_timing_gen: raster position, sync strobes,
// active-area flag, line/frame pulses and the frame counter.
interface vga_timing_gen_if;
   logic [9:0] hpos;
   logic [9:0] vpos;
   logic       hsync;
   logic       vsync;
   logic       visible;
   logic       line_start;
   logic       frame_start;
   logic [7:0] frame_count;

   modport master (
      output hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
   );

   modport slave (
      input hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with horizontal/vertical phase FSMs and registered outputs.
// Define VGA_TIMING_FRAME_CNT_EN to build the 8-bit frame counter; otherwise frame_count is 0.
module vga_timing_gen #(
   parameter int H_DISPLAY   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_DISPLAY   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter bit SYNC_ACTIVE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   vga_timing_gen_if.master vid
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_FP_START = 10'(H_DISPLAY);
   localparam logic [9:0] H_SY_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] H_BP_START = 10'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_FP_START = 10'(V_DISPLAY);
   localparam logic [9:0] V_SY_START = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] V_BP_START = 10'(V_DISPLAY + V_FRONT + V_SYNC);

   typedef enum logic [1:0] {H_ACT = 2'd0, H_FP = 2'd1, H_SY = 2'd2, H_BP = 2'd3} h_state_t;
   typedef enum logic [1:0] {V_ACT = 2'd0, V_FP = 2'd1, V_SY = 2'd2, V_BP = 2'd3} v_state_t;

   h_state_t   h_state_r, h_state_s;
   v_state_t   v_state_r, v_state_s;
   logic [9:0] h_cnt_r, h_cnt_s;
   logic [9:0] v_cnt_r, v_cnt_s;
   logic       h_wrap_s, v_wrap_s;
   logic       hsync_r, hsync_s;
   logic       vsync_r, vsync_s;
   logic       visible_r, visible_s;
   logic       line_start_r, line_start_s;
   logic       frame_start_r, frame_start_s;

   // Next position, phase states and output levels; all outputs derive from the next state
   // so that registered sync/visible describe the same position as registered hpos/vpos.
   always_comb begin
      h_cnt_s   = h_cnt_r;
      v_cnt_s   = v_cnt_r;
      h_state_s = h_state_r;
      v_state_s = v_state_r;
      h_wrap_s  = 1'b0;
      v_wrap_s  = 1'b0;
      if (ce) begin
         h_wrap_s = (h_cnt_r == H_LAST);
         if (h_wrap_s) begin
            h_cnt_s  = 10'd0;
            v_wrap_s = (v_cnt_r == V_LAST);
            if (v_wrap_s) begin
               v_cnt_s = 10'd0;
            end else begin
               v_cnt_s = v_cnt_r + 10'd1;
            end
         end else begin
            h_cnt_s = h_cnt_r + 10'd1;
         end

         case (h_state_r)
            H_ACT:   h_state_s = (h_cnt_s == H_FP_START) ? H_FP  : H_ACT;
            H_FP:    h_state_s = (h_cnt_s == H_SY_START) ? H_SY  : H_FP;
            H_SY:    h_state_s = (h_cnt_s == H_BP_START) ? H_BP  : H_SY;
            H_BP:    h_state_s = h_wrap_s                ? H_ACT : H_BP;
            default: h_state_s = H_ACT;
         endcase

         // Vertical phase only moves on a line wrap; a corrupt state still recovers at once.
         case (v_state_r)
            V_ACT:   v_state_s = (h_wrap_s && (v_cnt_s == V_FP_START)) ? V_FP  : V_ACT;
            V_FP:    v_state_s = (h_wrap_s && (v_cnt_s == V_SY_START)) ? V_SY  : V_FP;
            V_SY:    v_state_s = (h_wrap_s && (v_cnt_s == V_BP_START)) ? V_BP  : V_SY;
            V_BP:    v_state_s = v_wrap_s                              ? V_ACT : V_BP;
            default: v_state_s = V_ACT;
         endcase
      end else begin
         h_cnt_s = h_cnt_r;
      end

      hsync_s       = (h_state_s == H_SY) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_s       = (v_state_s == V_SY) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      visible_s     = (h_state_s == H_ACT) && (v_state_s == V_ACT);
      line_start_s  = h_wrap_s;
      frame_start_s = h_wrap_s && v_wrap_s;
   end

   // State, position and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_state_r     <= H_ACT;
         v_state_r     <= V_ACT;
         h_cnt_r       <= 10'd0;
         v_cnt_r       <= 10'd0;
         hsync_r       <= ~SYNC_ACTIVE;
         vsync_r       <= ~SYNC_ACTIVE;
         visible_r     <= 1'b1;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         h_state_r     <= h_state_s;
         v_state_r     <= v_state_s;
         h_cnt_r       <= h_cnt_s;
         v_cnt_r       <= v_cnt_s;
         hsync_r       <= hsync_s;
         vsync_r       <= vsync_s;
         visible_r     <= visible_s;
         line_start_r  <= line_start_s;
         frame_start_r <= frame_start_s;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [7:0] frame_cnt_r;

   // Frames completed since reset; steps in the same cycle frame_start is registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt_r <= 8'd0;
      end else if (frame_start_s) begin
         frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   assign vid.frame_count = frame_cnt_r;
`else
   assign vid.frame_count = 8'h00;
`endif

   assign vid.hpos        = h_cnt_r;
   assign vid.vpos        = v_cnt_r;
   assign vid.hsync       = hsync_r;
   assign vid.vsync       = vsync_r;
   assign vid.visible     = visible_r;
   assign vid.line_start  = line_start_r;
   assign vid.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line/ce checks, a small-raster instance
// (25x19, active-high sync) for whole-frame, frame counter and mid-frame reset checks.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, ce, rst_n_s, ce_s;
   int   n_checks = 0;
   int   n_fail   = 0;

`ifdef VGA_TIMING_FRAME_CNT_EN
   localparam int FC_STEP = 1;
`else
   localparam int FC_STEP = 0;
`endif

   vga_timing_gen_if vid ();
   vga_timing_gen_if vid_s ();

   vga_timing_gen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (ce),
      .vid   (vid)
   );

   vga_timing_gen #(
      .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
      .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .SYNC_ACTIVE(1'b1)
   ) dut_s (
      .clk   (clk),
      .rst_n (rst_n_s),
      .ce    (ce_s),
      .vid   (vid_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [32:0] exp_v;
      rst_n = 1'b0; ce = 1'b1; rst_n_s = 1'b0; ce_s = 1'b1;
      repeat (3) tick();
      exp_v = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
      n_checks++;
      if ({vid.hpos, vid.vpos, vid.hsync, vid.vsync, vid.visible, vid.line_start,
           vid.frame_start, vid.frame_count} !== exp_v) begin
         n_fail++;
         $display("FAIL reset_default got %h expected %h", {vid.hpos, vid.vpos, vid.hsync,
                  vid.vsync, vid.visible, vid.line_start, vid.frame_start, vid.frame_count}, exp_v);
      end
      exp_v = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      n_checks++;
      if ({vid_s.hpos, vid_s.vpos, vid_s.hsync, vid_s.vsync, vid_s.visible, vid_s.line_start,
           vid_s.frame_start, vid_s.frame_count} !== exp_v) begin
         n_fail++;
         $display("FAIL reset_small got %h expected %h", {vid_s.hpos, vid_s.vpos, vid_s.hsync,
                  vid_s.vsync, vid_s.visible, vid_s.line_start, vid_s.frame_start,
                  vid_s.frame_count}, exp_v);
      end
   endtask

   task automatic test_line();
      int   hs_cnt = 0;
      int   hs_first = -1;
      int   eh, ev;
      logic ehs, evis, els;
      rst_n = 1'b0; ce = 1'b0;
      tick();
      rst_n = 1'b1; ce = 1'b1;
      for (int i = 1; i <= 800; i++) begin
         tick();
         eh   = i % 800;
         ev   = (i == 800) ? 1 : 0;
         ehs  = !((eh >= 656) && (eh <= 751));
         evis = (eh < 640);
         els  = (i == 800);
         if (vid.hsync == 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(vid.hpos);
         end
         n_checks++;
         if (vid.hpos !== 10'(eh)) begin
            n_fail++; $display("FAIL line_hpos cycle %0d got %0d expected %0d", i, vid.hpos, eh);
         end
         n_checks++;
         if (vid.vpos !== 10'(ev)) begin
            n_fail++; $display("FAIL line_vpos cycle %0d got %0d expected %0d", i, vid.vpos, ev);
         end
         n_checks++;
         if (vid.hsync !== ehs) begin
            n_fail++; $display("FAIL line_hsync hpos %0d got %b expected %b", eh, vid.hsync, ehs);
         end
         n_checks++;
         if (vid.vsync !== 1'b1) begin
            n_fail++; $display("FAIL line_vsync hpos %0d got %b expected 1", eh, vid.vsync);
         end
         n_checks++;
         if (vid.visible !== evis) begin
            n_fail++; $display("FAIL line_visible hpos %0d got %b expected %b", eh, vid.visible, evis);
         end
         n_checks++;
         if (vid.line_start !== els) begin
            n_fail++; $display("FAIL line_start cycle %0d got %b expected %b", i, vid.line_start, els);
         end
         n_checks++;
         if (vid.frame_start !== 1'b0) begin
            n_fail++; $display("FAIL line_frame_start cycle %0d got %b expected 0", i, vid.frame_start);
         end
      end
      n_checks++;
      if (hs_cnt !== 96) begin
         n_fail++; $display("FAIL hsync_width got %0d expected 96", hs_cnt);
      end
      n_checks++;
      if (hs_first !== 656) begin
         n_fail++; $display("FAIL hsync_first got %0d expected 656", hs_first);
      end
   endtask

   task automatic test_ce_toggle();
      int   h = 0;
      int   v = 0;
      logic c, wrap, ehs;
      rst_n = 1'b0; ce = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 1600; i++) begin
         c  = (i % 2 == 0);
         ce = c;
         tick();
         wrap = c && (h == 799);
         if (c) begin
            h = wrap ? 0 : h + 1;
            if (wrap) v++;
         end
         ehs = !((h >= 656) && (h <= 751));
         n_checks++;
         if ({vid.hpos, vid.vpos} !== {10'(h), 10'(v)}) begin
            n_fail++;
            $display("FAIL ce_pos cycle %0d got (%0d,%0d) expected (%0d,%0d)", i, vid.hpos, vid.vpos, h, v);
         end
         n_checks++;
         if ({vid.line_start, vid.frame_start} !== {wrap, 1'b0}) begin
            n_fail++;
            $display("FAIL ce_pulses cycle %0d got %b%b expected %b0", i, vid.line_start, vid.frame_start, wrap);
         end
         n_checks++;
         if ({vid.hsync, vid.visible} !== {ehs, (h < 640)}) begin
            n_fail++;
            $display("FAIL ce_levels cycle %0d got %b%b expected %b%b", i, vid.hsync, vid.visible, ehs, (h < 640));
         end
      end
      ce = 1'b0;
   endtask

   task automatic test_frame();
      int   eh, ev, efc;
      int   vs_cnt = 0;
      int   fs_cnt = 0;
      logic ehs, evs, evis, els, efs;
      rst_n_s = 1'b0; ce_s = 1'b0;
      tick();
      rst_n_s = 1'b1; ce_s = 1'b1;
      for (int i = 1; i <= 950; i++) begin
         tick();
         eh   = i % 25;
         ev   = (i / 25) % 19;
         efc  = (i / 475) * FC_STEP;
         ehs  = (eh >= 18) && (eh <= 21);
         evs  = (ev == 14) || (ev == 15);
         evis = (eh < 16) && (ev < 12);
         els  = (i % 25 == 0);
         efs  = (i % 475 == 0);
         if (vid_s.vsync == 1'b1) vs_cnt++;
         if (vid_s.frame_start == 1'b1) fs_cnt++;
         n_checks++;
         if ({vid_s.hpos, vid_s.vpos} !== {10'(eh), 10'(ev)}) begin
            n_fail++;
            $display("FAIL frame_pos cycle %0d got (%0d,%0d) expected (%0d,%0d)", i, vid_s.hpos, vid_s.vpos, eh, ev);
         end
         n_checks++;
         if ({vid_s.hsync, vid_s.vsync, vid_s.visible} !== {ehs, evs, evis}) begin
            n_fail++;
            $display("FAIL frame_levels (%0d,%0d) got %b%b%b expected %b%b%b", eh, ev,
                     vid_s.hsync, vid_s.vsync, vid_s.visible, ehs, evs, evis);
         end
         n_checks++;
         if ({vid_s.line_start, vid_s.frame_start} !== {els, efs}) begin
            n_fail++;
            $display("FAIL frame_pulses cycle %0d got %b%b expected %b%b", i,
                     vid_s.line_start, vid_s.frame_start, els, efs);
         end
         n_checks++;
         if (vid_s.frame_count !== 8'(efc)) begin
            n_fail++;
            $display("FAIL frame_count cycle %0d got %0d expected %0d", i, vid_s.frame_count, efc);
         end
      end
      n_checks++;
      if (vs_cnt !== 100) begin
         n_fail++; $display("FAIL vsync_cycles got %0d expected 100", vs_cnt);
      end
      n_checks++;
      if (fs_cnt !== 2) begin
         n_fail++; $display("FAIL frame_start_count got %0d expected 2", fs_cnt);
      end
   endtask

   task automatic test_mid_reset();
      logic [32:0] exp_v;
      ce_s = 1'b1;
      repeat (132) tick();
      n_checks++;
      if ({vid_s.hpos, vid_s.vpos} !== {10'd7, 10'd5}) begin
         n_fail++;
         $display("FAIL midrst_pre got (%0d,%0d) expected (7,5)", vid_s.hpos, vid_s.vpos);
      end
      rst_n_s = 1'b0;
      tick();
      exp_v = {10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      n_checks++;
      if ({vid_s.hpos, vid_s.vpos, vid_s.hsync, vid_s.vsync, vid_s.visible, vid_s.line_start,
           vid_s.frame_start, vid_s.frame_count} !== exp_v) begin
         n_fail++;
         $display("FAIL midrst_state got %h expected %h", {vid_s.hpos, vid_s.vpos, vid_s.hsync,
                  vid_s.vsync, vid_s.visible, vid_s.line_start, vid_s.frame_start,
                  vid_s.frame_count}, exp_v);
      end
      rst_n_s = 1'b1;
      tick();
      n_checks++;
      if ({vid_s.hpos, vid_s.vpos, vid_s.frame_start} !== {10'd1, 10'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL midrst_release got (%0d,%0d) fs %b expected (1,0) fs 0",
                  vid_s.hpos, vid_s.vpos, vid_s.frame_start);
      end
      ce_s = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ce = 1'b0; rst_n_s = 1'b0; ce_s = 1'b0;
      test_reset();
      test_line();
      test_ce_toggle();
      test_frame();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT 16, H_SYNC 96, H_BACK 48, giving horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_DISPLAY 480, V_FRONT 10, V_SYNC 2, V_BACK 33, giving vertical lines.
REQ-004 SHALL have parameter SYNC_ACTIVE, default 0, the asserted level of hsync/vsync.
REQ-005 clk  input  1  pixel clock; all logic on posedge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 ce  input  1  pixel clock enable; counters advance only when 1.
REQ-008 hpos  output  10  current column, 0..H_TOTAL-1.
REQ-009 vpos  output  10  current line, 0..V_TOTAL-1.
REQ-010 hsync, vsync  output  1 each  sync strobes at SYNC_ACTIVE level.
REQ-011 visible  output  1  high when the current position is in the active area.
REQ-012 line_start, frame_start  output  1 each  single-cycle pulses.
REQ-013 frame_count  output  8  frames completed since reset.

Function
REQ-014 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL equal the V sum (525).
REQ-015 Horizontal FSM SHALL have states H_ACT, H_FP, H_SY, H_BP, entered at hpos 0, H_DISPLAY, H_DISPLAY+H_FRONT, and H_DISPLAY+H_FRONT+H_SYNC respectively; H_BP SHALL return to H_ACT on wrap.
REQ-016 Vertical FSM SHALL have states V_ACT, V_FP, V_SY, V_BP with the same boundaries on vpos and SHALL advance only on hpos wrap.
REQ-017 On each ce=1 cycle, hpos SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vpos SHALL increment, wrapping from V_TOTAL-1 to 0.
REQ-018 When ce=0, all counters, FSM states and level outputs SHALL hold, and line_start/frame_start SHALL be 0.
REQ-019 All outputs SHALL be registered and mutually aligned: hsync, vsync and visible SHALL describe the same (hpos,vpos) presented in that cycle, with no combinational path from ce to outputs.
REQ-020 hsync SHALL equal SYNC_ACTIVE exactly when hpos is in [656,751]; vsync SHALL equal SYNC_ACTIVE exactly when vpos is in [490,491] (defaults).
REQ-021 visible SHALL be 1 exactly when hpos<H_DISPLAY and vpos<V_DISPLAY.
REQ-022 line_start SHALL be 1 for the single cycle in which hpos becomes 0 through a wrap.
REQ-023 frame_start SHALL be 1 for the single cycle in which hpos and vpos both become 0 through a wrap; line_start SHALL also be 1 in that cycle.
REQ-024 frame_count SHALL increment modulo 256 in the cycle that frame_start asserts.
REQ-025 An FSM state that is not reachable SHALL recover to H_ACT/V_ACT on the next ce cycle.

Reset
REQ-026 While rst_n=0 at posedge, the block SHALL set hpos=0, vpos=0, both FSMs to *_ACT, visible=1, hsync=vsync=~SYNC_ACTIVE, line_start=frame_start=0 and frame_count=0, regardless of ce.
REQ-027 Reset asserted mid-frame SHALL restart timing at (0,0) with no frame_start pulse; the first ce cycle after release SHALL give hpos=1.

Configuration
REQ-028 Macro VGA_TIMING_FRAME_CNT_EN defined: frame_count SHALL behave per REQ-024.
REQ-029 Macro VGA_TIMING_FRAME_CNT_EN undefined: frame_count SHALL be tied to 8'h00, no counter register SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Reset, then 800 ce cycles -> hpos returns to 0, vpos=1, line_start high in exactly that cycle, frame_start low.
REQ-031 Run 420000 ce cycles from reset -> frame_start pulses exactly once, at cycle 420000, with hpos=vpos=0; frame_count=1 (0 if macro undefined).
REQ-032 Sweep one line -> hsync active for exactly 96 cycles starting at hpos=656; visible high for hpos 0..639 only on lines 0..479.
REQ-033 Sweep one frame -> vsync active exactly on lines 490 and 491 (1600 cycles); visible low on all of lines 480..524.
REQ-034 Toggle ce at 50% duty -> hpos advances only on ce=1 cycles, outputs hold on ce=0 cycles, no pulses while ce=0.
REQ-035 Assert rst_n=0 at hpos=300, vpos=200 for one cycle -> next cycle shows (0,0), visible=1, syncs inactive, frame_count=0, no frame_start.
